// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART clock-control frame path.
// Holds the frame constants, the field bit positions (also used by uart_decode),
// the field limits, the frame-controller state encoding and the field range check.
package uart_frame_ctrl_pkg;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam int         FRAME_BYTES = 17;
  localparam int         FRAME_W     = FRAME_BYTES * 8;

  // LSB positions of fields inside the 136-bit frame.
  // Hour fields and minute/second fields are all 6 bits wide.
  localparam int MODE_LSB        = 120;
  localparam int ADJ_HOUR_LSB    = 96;
  localparam int ADJ_MIN_LSB     = 88;
  localparam int ADJ_SEC_LSB     = 80;
  localparam int ALARM1_HOUR_LSB = 72;
  localparam int ALARM1_MIN_LSB  = 64;
  localparam int ALARM1_SEC_LSB  = 56;
  localparam int ALARM2_HOUR_LSB = 48;
  localparam int ALARM2_MIN_LSB  = 40;
  localparam int ALARM2_SEC_LSB  = 32;
  localparam int ALARM3_HOUR_LSB = 24;
  localparam int ALARM3_MIN_LSB  = 16;
  localparam int ALARM3_SEC_LSB  = 8;

  localparam logic [5:0] MAX_HOUR   = 6'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } frame_state_t;

  // Hours are stored 0..23 regardless of the 12/24-h display mode.
  function automatic logic range_ok(input logic [FRAME_W-1:0] f);
    logic ok;
    ok = 1'b1;
    if (f[ADJ_HOUR_LSB    +: 6] > MAX_HOUR)   ok = 1'b0;
    if (f[ALARM1_HOUR_LSB +: 6] > MAX_HOUR)   ok = 1'b0;
    if (f[ALARM2_HOUR_LSB +: 6] > MAX_HOUR)   ok = 1'b0;
    if (f[ALARM3_HOUR_LSB +: 6] > MAX_HOUR)   ok = 1'b0;
    if (f[ADJ_MIN_LSB     +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ADJ_SEC_LSB     +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM1_MIN_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM1_SEC_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM2_MIN_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM2_SEC_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM3_MIN_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    if (f[ALARM3_SEC_LSB  +: 6] > MAX_MINSEC) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: assembles UART RX bytes into the 17-byte clock control frame
// for uart_decode. Checks header, checksum, field ranges and inter-byte timeout,
// and only commits complete, good frames to o_frame.
//
// state | meaning
// IDLE  | waiting for a header byte; other bytes are dropped silently
// RECV  | collecting payload and checksum bytes, inter-byte timer running
// CHECK | one cycle: verify checksum and ranges, commit or discard
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous reset, active-low
//   i_rx_data[7:0]  received byte
//   i_rx_valid      one-cycle strobe qualifying i_rx_data
//   o_frame[135:0]  last committed frame
//   o_frame_update  one-cycle pulse when o_frame takes a new value
//   o_busy          high while a frame is being collected or checked
//   o_err_chksum    one-cycle pulse, checksum mismatch
//   o_err_range     one-cycle pulse, field out of range
//   o_err_timeout   one-cycle pulse, inter-byte timeout
//   o_err_cnt[7:0]  saturating count of discarded frames
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [135:0] o_frame,
  output logic         o_frame_update,
  output logic         o_busy,
  output logic         o_err_chksum,
  output logic         o_err_range,
  output logic         o_err_timeout,
  output logic [7:0]   o_err_cnt
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]       LAST_IDX = 5'(FRAME_BYTES - 1);

  frame_state_t       r_state;
  logic [135:0]       r_sreg;
  logic [4:0]         r_byte_cnt;
  logic [7:0]         r_sum;
  logic [TMO_W-1:0]   r_tmo;
  logic [135:0]       r_frame;
  logic               r_frame_update;
  logic               r_busy;
  logic               r_err_chksum;
  logic               r_err_range;
  logic               r_err_timeout;
  logic [7:0]         r_err_cnt;

  logic               w_hdr;

  assign w_hdr = i_rx_valid && (i_rx_data == HEADER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sreg         <= '0;
      r_byte_cnt     <= '0;
      r_sum          <= '0;
      r_tmo          <= '0;
      r_frame        <= '0;
      r_frame_update <= 1'b0;
      r_busy         <= 1'b0;
      r_err_chksum   <= 1'b0;
      r_err_range    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      r_frame_update <= 1'b0;
      r_err_chksum   <= 1'b0;
      r_err_range    <= 1'b0;
      r_err_timeout  <= 1'b0;

      case (r_state)
        ST_IDLE, ST_CHECK: begin
          if (r_state == ST_CHECK) begin
            if (r_sreg[7:0] != r_sum) begin
              r_err_chksum <= 1'b1;
              r_err_cnt    <= sat_inc8(r_err_cnt);
            end else if (!range_ok(r_sreg)) begin
              r_err_range <= 1'b1;
              r_err_cnt   <= sat_inc8(r_err_cnt);
            end else begin
              r_frame        <= r_sreg;
              r_frame_update <= 1'b1;
            end
          end
          // The check cycle also accepts a new header, so frames can abut.
          if (w_hdr) begin
            r_sreg     <= {128'd0, i_rx_data};
            r_byte_cnt <= 5'd1;
            r_sum      <= '0;
            r_tmo      <= TMO_LOAD;
            r_state    <= ST_RECV;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_RECV: begin
          if (i_rx_valid) begin
            r_sreg     <= {r_sreg[127:0], i_rx_data};
            r_byte_cnt <= r_byte_cnt + 5'd1;
            r_tmo      <= TMO_LOAD;
            // r_byte_cnt is the index of the incoming byte; index 16 is the checksum.
            if (r_byte_cnt < LAST_IDX) r_sum <= r_sum + i_rx_data;
            if (r_byte_cnt == LAST_IDX) r_state <= ST_CHECK;
          end else if (r_tmo == '0) begin
            r_err_timeout <= 1'b1;
            r_err_cnt     <= sat_inc8(r_err_cnt);
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_frame        = r_frame;
  assign o_frame_update = r_frame_update;
  assign o_busy         = r_busy;
  assign o_err_chksum   = r_err_chksum;
  assign o_err_range    = r_err_range;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl: byte-level reference model compared every cycle,
// plus directed literal checks on the documented scenarios.
module tb_uart_frame_ctrl;

  localparam int T = 40;  // reduced inter-byte timeout for simulation

  logic         clk;
  logic         rst_n;
  logic [7:0]   i_rx_data;
  logic         i_rx_valid;
  logic [135:0] o_frame;
  logic         o_frame_update;
  logic         o_busy;
  logic         o_err_chksum;
  logic         o_err_range;
  logic         o_err_timeout;
  logic [7:0]   o_err_cnt;

  uart_frame_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_frame        (o_frame),
    .o_frame_update (o_frame_update),
    .o_busy         (o_busy),
    .o_err_chksum   (o_err_chksum),
    .o_err_range    (o_err_range),
    .o_err_timeout  (o_err_timeout),
    .o_err_cnt      (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit is_hour(input int i);
    return (i == 4) || (i == 7) || (i == 10) || (i == 13);
  endfunction

  function automatic bit is_ms(input int i);
    return (i == 5) || (i == 6) || (i == 8) || (i == 9) || (i == 11) ||
           (i == 12) || (i == 14) || (i == 15);
  endfunction

  // ---------------- reference model (byte lists, not bit registers) --------
  logic [7:0]   m_q[$];
  logic [7:0]   m_pb[17];
  bit           m_pend;
  int           m_gap;
  logic [135:0] m_frame;
  bit           m_upd, m_ec, m_er, m_et, m_busy;
  int           m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_gap = 0; m_frame = '0;
    m_upd = 0; m_ec = 0; m_er = 0; m_et = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    int  s;
    bit  rng;
    bit  was_pend;
    m_upd = 0; m_ec = 0; m_er = 0; m_et = 0;
    was_pend = m_pend;
    m_pend = 0;
    if (was_pend) begin
      s = 0;
      for (int i = 1; i <= 15; i++) s += int'(m_pb[i]);
      rng = 1;
      for (int i = 1; i <= 15; i++) begin
        if (is_hour(i) && int'(m_pb[i] & 8'h3F) > 23) rng = 0;
        if (is_ms(i)   && int'(m_pb[i] & 8'h3F) > 59) rng = 0;
      end
      if ((s % 256) != int'(m_pb[16])) begin
        m_ec = 1; if (m_cnt < 255) m_cnt++;
      end else if (!rng) begin
        m_er = 1; if (m_cnt < 255) m_cnt++;
      end else begin
        for (int i = 0; i < 17; i++) m_frame[(16 - i) * 8 +: 8] = m_pb[i];
        m_upd = 1;
      end
    end
    if (m_q.size() > 0) begin
      if (v) begin
        m_q.push_back(d);
        m_gap = 0;
        if (m_q.size() == 17) begin
          for (int i = 0; i < 17; i++) m_pb[i] = m_q[i];
          m_q.delete();
          m_pend = 1;
        end
      end else begin
        m_gap++;
        if (m_gap == T) begin
          m_et = 1; if (m_cnt < 255) m_cnt++;
          m_q.delete();
        end
      end
    end else if (v && d == 8'hA5) begin
      m_q.push_back(d);
      m_gap = 0;
    end
    m_busy = (m_q.size() > 0) || m_pend;
  endtask

  // Compare process: model advances on each active edge, DUT sampled 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(i_rx_valid, i_rx_data);
      #1;
      chk("frame",        o_frame,        m_frame);
      chk("frame_update", o_frame_update, m_upd);
      chk("busy",         o_busy,         m_busy);
      chk("err_chksum",   o_err_chksum,   m_ec);
      chk("err_range",    o_err_range,    m_er);
      chk("err_timeout",  o_err_timeout,  m_et);
      chk("err_cnt",      o_err_cnt,      m_cnt[7:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fb[17];

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // gap_max: maximum idle cycles between bytes (at least 1 always)
  task automatic send_frame(input int gap_max);
    for (int i = 0; i < 17; i++) begin
      send(fb[i]);
      if (i < 16 && gap_max > 1) begin
        if ($urandom_range(0, 7) == 0) idle(T - 2);  // exactly T-1 idle cycles
        else idle($urandom_range(0, gap_max - 1));
      end
    end
  endtask

  task automatic fix_cs();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i <= 15; i++) s = s + fb[i];
    fb[16] = s;
  endtask

  task automatic set_f0();
    for (int i = 0; i < 17; i++) fb[i] = 8'h00;
    fb[0] = 8'hA5; fb[1] = 8'h01; fb[4] = 8'h0C; fb[5] = 8'h1E; fb[6] = 8'h2D;
    fb[16] = 8'h58;
  endtask

  task automatic gen_good();
    fb[0] = 8'hA5;
    for (int i = 1; i <= 15; i++) begin
      fb[i] = 8'($urandom);
      if (is_hour(i)) fb[i] = {fb[i][7:6], 6'($urandom_range(0, 23))};
      if (is_ms(i))   fb[i] = {fb[i][7:6], 6'($urandom_range(0, 59))};
    end
    fix_cs();
  endtask

  localparam logic [135:0] F0 = 136'hA5_01_00_00_0C_1E_2D_00_00_00_00_00_00_00_00_00_58;
  localparam logic [135:0] F3 = 136'hA5_01_00_A5_0C_1E_2D_00_00_00_00_00_00_00_00_00_FD;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int found;
    int kind;
    int k;
    logic [7:0] nb;
    rst_n      = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    idle(3);
    chk("rst_frame",   o_frame,   136'd0);
    chk("rst_busy",    o_busy,    1'b0);
    chk("rst_err_cnt", o_err_cnt, 8'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, latency N+2
    set_f0();
    send_frame(1);
    chk("f0_busy_in_check", o_busy, 1'b1);
    chk("f0_no_upd_yet",    o_frame_update, 1'b0);
    @(posedge clk); #2;
    chk("f0_upd",      o_frame_update, 1'b1);
    chk("f0_mode",     o_frame[122:120], 3'd1);
    chk("f0_hour",     o_frame[101:96], 6'd12);
    chk("f0_frame",    o_frame, F0);
    chk("f0_err_cnt",  o_err_cnt, 8'd0);
    idle(3);

    // Checksum off by one
    set_f0(); fb[16] = 8'h59;
    send_frame(1);
    @(posedge clk); #2;
    chk("cs_pulse",   o_err_chksum, 1'b1);
    chk("cs_no_upd",  o_frame_update, 1'b0);
    chk("cs_frame",   o_frame, F0);
    chk("cs_err_cnt", o_err_cnt, 8'd1);
    idle(3);

    // adjust_minute = 60, checksum valid
    set_f0(); fb[5] = 8'h3C; fb[16] = 8'h76;
    send_frame(1);
    @(posedge clk); #2;
    chk("rng_pulse",   o_err_range, 1'b1);
    chk("rng_cs_ok",   o_err_chksum, 1'b0);
    chk("rng_no_upd",  o_frame_update, 1'b0);
    chk("rng_err_cnt", o_err_cnt, 8'd2);
    idle(3);

    // Header + 5 bytes, then silence: timeout after exactly T idle cycles
    set_f0();
    for (int i = 0; i < 6; i++) send(fb[i]);
    found = 0;
    for (int i = 1; i <= T + 5; i++) begin
      @(posedge clk); #2;
      if (o_err_timeout && found == 0) found = i;
    end
    chk("tmo_cycle",   found, T);
    chk("tmo_busy",    o_busy, 1'b0);
    chk("tmo_err_cnt", o_err_cnt, 8'd3);

    // Good frame with T-1 idle cycles between every byte: no timeout
    set_f0();
    for (int i = 0; i < 17; i++) begin
      send(fb[i]);
      if (i < 16) idle(T - 2);
    end
    @(posedge clk); #2;
    chk("gapmax_upd",     o_frame_update, 1'b1);
    chk("gapmax_err_cnt", o_err_cnt, 8'd3);
    idle(3);

    // Noise before header
    send(8'h00); send(8'h55);
    chk("noise_busy",    o_busy, 1'b0);
    chk("noise_err_cnt", o_err_cnt, 8'd3);
    // A5 as payload byte 3
    set_f0(); fb[3] = 8'hA5; fb[16] = 8'hFD;
    send_frame(1);
    @(posedge clk); #2;
    chk("a5_upd",   o_frame_update, 1'b1);
    chk("a5_frame", o_frame, F3);
    idle(3);

    // Reset after 8 bytes
    set_f0();
    for (int i = 0; i < 8; i++) send(fb[i]);
    rst_n = 1'b0;
    #2;
    chk("mrst_frame",   o_frame, 136'd0);
    chk("mrst_busy",    o_busy, 1'b0);
    chk("mrst_err_cnt", o_err_cnt, 8'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(1);
    @(posedge clk); #2;
    chk("mrst_next_frame", o_frame, F0);
    idle(3);

    // Randomised traffic, checked by the per-cycle model
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      gen_good();
      case (kind)
        5: begin
          fb[16] = fb[16] ^ 8'($urandom_range(1, 255));
          send_frame(6);
        end
        6: begin
          k = $urandom_range(0, 1) ? 4 + 3 * $urandom_range(0, 3) : 5;
          if (is_hour(k)) fb[k] = {fb[k][7:6], 6'($urandom_range(24, 63))};
          else            fb[k] = {fb[k][7:6], 6'($urandom_range(60, 63))};
          fix_cs();
          send_frame(6);
        end
        7: begin
          k = $urandom_range(0, 15);
          for (int i = 0; i <= k; i++) send(fb[i]);
          idle(T + $urandom_range(0, 3));
        end
        8: begin
          for (int i = 0; i < $urandom_range(1, 3); i++) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h5A;
            send(nb);
          end
        end
        9: begin
          k = $urandom_range(1, 3);
          fb[k] = 8'hA5;
          fix_cs();
          send_frame(6);
        end
        default: send_frame(6);
      endcase
      idle($urandom_range(0, 3));
    end
    idle(5);

    // Saturation of the error counter
    set_f0(); fb[16] = 8'h00;
    for (int n = 0; n < 256; n++) send_frame(1);
    idle(3);
    chk("sat_err_cnt", o_err_cnt, 8'hFF);
    send_frame(1);
    idle(3);
    chk("sat_hold", o_err_cnt, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
